ip_udp_frame_tx: RTL and testbench
==================================

# ip_udp_frame_tx

Parametrised Ethernet/IPv4 frame transmitter with optional UDP header insertion, byte-granular payload length and IP fragmentation fields. It accepts one frame request at a time, latches every header field, computes the IPv4 header checksum, then emits the frame as a 32-bit stream: Ethernet header, IP header, optional UDP header, payload. It sits between the payload source (FIFO/packetiser) and the MAC transmit stream interface.

## Interface
- TTL, 8'hC8, IPv4 TTL field.
- DSCP_ECN, 8'h00, IPv4 DSCP/ECN byte.
- UDP_EN, 1, 1: insert 8-byte UDP header and force protocol to 8'd17; 0: no UDP header, protocol = i_protocol.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  frame request; accepted in a cycle where i_start & o_ready.
- o_ready  out  1  high only in IDLE.
- o_err  out  1  one-cycle pulse when a request is rejected.
- i_dst_mac, i_src_mac  in  48  MAC addresses.
- i_dst_ip, i_src_ip  in  32  IPv4 addresses.
- i_protocol  in  8  IP protocol (UDP_EN=0 only).
- i_src_port, i_dst_port  in  16  UDP ports (UDP_EN=1 only).
- i_pkt_id  in  16  IP identification.
- i_more_frame  in  1  MF flag.
- i_frame_offset  in  16  fragment offset in bytes; bits [2:0] ignored.
- i_payload_len  in  16  payload bytes.
- i_in_data  in  32  payload, first byte in [31:24].
- i_in_vld  in  1  payload valid.
- o_in_rdy  out  1  payload accepted when i_in_vld & o_in_rdy.
- o_eth_data  out  32  frame word, first byte in [31:24].
- o_eth_sop, o_eth_eop  out  1  first/last word markers (qualified by o_eth_vld).
- o_eth_empty  out  2  unused trailing bytes of the eop word; 0 otherwise.
- o_eth_vld  out  1  word valid.
- i_eth_rdy  in  1  sink ready; word transfers when o_eth_vld & i_eth_rdy.

## Operation
- States: IDLE -> CALC -> ETH0..ETH3 -> IP0..IP4 -> [UDP0, UDP1 if UDP_EN] -> PAYLOAD -> IDLE.
- IDLE: on accept, latch all header inputs and i_payload_len; go CALC. Reject (no latch, stay IDLE, o_err=1 next cycle) if i_payload_len==0 with UDP_EN=0, or total length > 16'hFFFF.
- CALC: one cycle, registers checksum; o_eth_vld=0.
- Words: ETH0 {16'h0000, dst_mac[47:32]} with sop; ETH1 dst_mac[31:0]; ETH2 src_mac[47:16]; ETH3 {src_mac[15:0], 16'h0800}.
- IP0 {4'h4, 4'h5, DSCP_ECN, total_len}, total_len = len + 20 + (UDP_EN ? 8 : 0), 17-bit compare for overflow.
- IP1 {pkt_id, 1'b0, DF, MF, offset[15:3]}; MF = i_more_frame; DF = 1 only when MF=0 and offset[15:3]=0.
- IP2 {TTL, proto, csum}; IP3 src_ip; IP4 dst_ip.
- csum = ~fold(sum of the ten header halfwords with csum=0); 32-bit accumulator, end-around carry folded twice.
- UDP0 {src_port, dst_port}; UDP1 {len+8, 16'h0000} (UDP checksum disabled).
- Header words: o_eth_vld=1, held stable until i_eth_rdy; advance on transfer.
- PAYLOAD: o_in_rdy = i_eth_rdy, o_eth_vld = i_in_vld, o_eth_data = i_in_data with bytes beyond the payload length zeroed. 16-bit remaining-bytes counter decrements by 4 per transfer; word with remaining ≤ 4 is eop, empty = (4 - len[1:0]) mod 4; transfer of it -> IDLE.
- UDP_EN=1, len==0: PAYLOAD skipped; UDP1 carries eop, empty=0.
- o_in_rdy = 0 outside PAYLOAD; payload never consumed during header.
- i_start outside IDLE ignored; latched fields immune to input changes mid-frame.
- rst at any point: immediate return to IDLE, frame truncated (no eop), source not drained.

## Timing
- Reset values: o_ready=1, o_err=0, o_in_rdy=0, o_eth_vld=0, o_eth_sop=0, o_eth_eop=0, o_eth_empty=0, o_eth_data=0.
- Accept in cycle N -> CALC in N+1 -> ETH0 presented in N+2 (2-cycle latency with i_eth_rdy held high).
- Header is 9 words (11 with UDP); unstalled frame occupies 2 + 9/11 + ceil(len/4) cycles.
- o_ready rises the cycle after the eop transfer; next accept at earliest that cycle.
- Payload path combinational in->out (zero-latency); sink must not sample data without vld.

## Test plan
- UDP_EN=1, len=10, rdy=1: accept -> sop 2 cycles later, 11 header words, IP0 low half 16'h0026, UDP1 {16'h0012,0}, 3 payload words, eop word empty=2 with bytes [15:0] zero.
- Checksum: src 192.168.1.10, dst 192.168.1.1, id 0, len 18 total 46, TTL C8, proto 17, DF=1 -> IP2 low half = reference-model ones'-complement value; header re-sums to 16'hFFFF.
- Backpressure: i_eth_rdy toggling 1/0 every cycle and i_in_vld gaps -> no word duplicated or dropped, data stable while stalled, o_in_rdy=0 throughout header.
- Fragment: more=1, offset=1480 -> IP1 = {id, 3'b001, 13'd185}; offset=0, more=0 -> 3'b010.
- Reject: UDP_EN=0, len=0 -> o_err pulse, o_ready stays 1, no vld; len=16'hFFF0 -> reject.
- rst asserted mid-payload -> all outputs reset values next edge, new frame then sent correctly.

Source files
------------

// File: rtl/ip_udp_frame_tx.sv
// Ethernet/IPv4 frame transmitter with optional UDP header. It latches one request,
// computes the IPv4 header checksum, then streams header and payload as 32-bit words.
module ip_udp_frame_tx #(
   parameter logic [7:0] TTL      = 8'hC8,
   parameter logic [7:0] DSCP_ECN = 8'h00,
   parameter logic       UDP_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   output logic        o_ready,
   output logic        o_err,
   input  logic [47:0] i_dst_mac,
   input  logic [47:0] i_src_mac,
   input  logic [31:0] i_dst_ip,
   input  logic [31:0] i_src_ip,
   input  logic [7:0]  i_protocol,
   input  logic [15:0] i_src_port,
   input  logic [15:0] i_dst_port,
   input  logic [15:0] i_pkt_id,
   input  logic        i_more_frame,
   input  logic [15:0] i_frame_offset,
   input  logic [15:0] i_payload_len,
   input  logic [31:0] i_in_data,
   input  logic        i_in_vld,
   output logic        o_in_rdy,
   output logic [31:0] o_eth_data,
   output logic        o_eth_sop,
   output logic        o_eth_eop,
   output logic [1:0]  o_eth_empty,
   output logic        o_eth_vld,
   input  logic        i_eth_rdy
);

   typedef enum logic [3:0] {
      S_IDLE, S_CALC, S_ETH0, S_ETH1, S_ETH2, S_ETH3,
      S_IP0, S_IP1, S_IP2, S_IP3, S_IP4, S_UDP0, S_UDP1, S_PAYLOAD
   } state_t;

   localparam logic [16:0] HDR_LEN = UDP_EN ? 17'd28 : 17'd20;

   state_t      state_reg, state_next;
   logic [47:0] dst_mac_reg, src_mac_reg;
   logic [31:0] dst_ip_reg, src_ip_reg;
   logic [7:0]  proto_reg;
   logic [15:0] src_port_reg, dst_port_reg, pkt_id_reg;
   logic [15:0] len_reg, total_len_reg, rem_reg, csum_reg;
   logic        mf_reg;
   logic [12:0] frag_reg;
   logic        err_reg;

   logic [16:0] total_len;
   logic        accept, reject, df, last_word;
   logic [31:0] csum_sum;
   logic [16:0] csum_fold1;
   logic [15:0] csum_fold2;
   logic [31:0] pay_mask;
   logic        unused_offset_bits;

   // 17-bit sum so an oversize frame shows up as a carry into bit 16
   assign total_len = {1'b0, i_payload_len} + HDR_LEN;
   assign reject    = total_len[16] | (!UDP_EN && i_payload_len == 16'd0);
   assign accept    = i_start && (state_reg == S_IDLE);
   assign df        = !mf_reg && (frag_reg == 13'd0);
   assign last_word = (rem_reg <= 16'd4);
   assign unused_offset_bits = ^i_frame_offset[2:0];

   assign o_ready = (state_reg == S_IDLE);
   assign o_err   = err_reg;

   assign csum_sum = {16'h0, 8'h45, DSCP_ECN} + {16'h0, total_len_reg} + {16'h0, pkt_id_reg}
                   + {16'h0, 1'b0, df, mf_reg, frag_reg} + {16'h0, TTL, proto_reg}
                   + {16'h0, src_ip_reg[31:16]} + {16'h0, src_ip_reg[15:0]}
                   + {16'h0, dst_ip_reg[31:16]} + {16'h0, dst_ip_reg[15:0]};
   // second fold cannot carry again: a first-fold carry leaves the low half at most 16'hFFFE
   assign csum_fold1 = {1'b0, csum_sum[15:0]} + {1'b0, csum_sum[31:16]};
   assign csum_fold2 = csum_fold1[15:0] + {15'd0, csum_fold1[16]};

   always_comb begin
      pay_mask = 32'hFFFF_FFFF;
      case (rem_reg)
         16'd1:   pay_mask = 32'hFF00_0000;
         16'd2:   pay_mask = 32'hFFFF_0000;
         16'd3:   pay_mask = 32'hFFFF_FF00;
         default: pay_mask = 32'hFFFF_FFFF;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      o_eth_vld   = 1'b0;
      o_eth_data  = 32'h0;
      o_eth_sop   = 1'b0;
      o_eth_eop   = 1'b0;
      o_eth_empty = 2'd0;
      o_in_rdy    = 1'b0;
      case (state_reg)
         S_IDLE: if (accept && !reject) state_next = S_CALC;
         S_CALC: state_next = S_ETH0;
         S_ETH0: begin
            o_eth_vld  = 1'b1;
            o_eth_sop  = 1'b1;
            o_eth_data = {16'h0000, dst_mac_reg[47:32]};
            if (i_eth_rdy) state_next = S_ETH1;
         end
         S_ETH1: begin
            o_eth_vld  = 1'b1;
            o_eth_data = dst_mac_reg[31:0];
            if (i_eth_rdy) state_next = S_ETH2;
         end
         S_ETH2: begin
            o_eth_vld  = 1'b1;
            o_eth_data = src_mac_reg[47:16];
            if (i_eth_rdy) state_next = S_ETH3;
         end
         S_ETH3: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {src_mac_reg[15:0], 16'h0800};
            if (i_eth_rdy) state_next = S_IP0;
         end
         S_IP0: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {8'h45, DSCP_ECN, total_len_reg};
            if (i_eth_rdy) state_next = S_IP1;
         end
         S_IP1: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {pkt_id_reg, 1'b0, df, mf_reg, frag_reg};
            if (i_eth_rdy) state_next = S_IP2;
         end
         S_IP2: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {TTL, proto_reg, csum_reg};
            if (i_eth_rdy) state_next = S_IP3;
         end
         S_IP3: begin
            o_eth_vld  = 1'b1;
            o_eth_data = src_ip_reg;
            if (i_eth_rdy) state_next = S_IP4;
         end
         S_IP4: begin
            o_eth_vld  = 1'b1;
            o_eth_data = dst_ip_reg;
            if (i_eth_rdy) state_next = UDP_EN ? S_UDP0 : S_PAYLOAD;
         end
         S_UDP0: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {src_port_reg, dst_port_reg};
            if (i_eth_rdy) state_next = S_UDP1;
         end
         S_UDP1: begin
            o_eth_vld  = 1'b1;
            o_eth_data = {len_reg + 16'd8, 16'h0000};
            o_eth_eop  = (len_reg == 16'd0);
            if (i_eth_rdy) state_next = (len_reg == 16'd0) ? S_IDLE : S_PAYLOAD;
         end
         S_PAYLOAD: begin
            // payload passes straight through; only the tail bytes are masked
            o_in_rdy   = i_eth_rdy;
            o_eth_vld  = i_in_vld;
            o_eth_data = i_in_data & pay_mask;
            if (last_word && i_in_vld) begin
               o_eth_eop   = 1'b1;
               o_eth_empty = 2'd0 - len_reg[1:0];
            end
            if (i_in_vld && i_eth_rdy && last_word) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         err_reg       <= 1'b0;
         dst_mac_reg   <= 48'h0;
         src_mac_reg   <= 48'h0;
         dst_ip_reg    <= 32'h0;
         src_ip_reg    <= 32'h0;
         proto_reg     <= 8'h0;
         src_port_reg  <= 16'h0;
         dst_port_reg  <= 16'h0;
         pkt_id_reg    <= 16'h0;
         mf_reg        <= 1'b0;
         frag_reg      <= 13'h0;
         len_reg       <= 16'h0;
         total_len_reg <= 16'h0;
         rem_reg       <= 16'h0;
         csum_reg      <= 16'h0;
      end else begin
         state_reg <= state_next;
         err_reg   <= accept && reject;
         if (accept && !reject) begin
            dst_mac_reg   <= i_dst_mac;
            src_mac_reg   <= i_src_mac;
            dst_ip_reg    <= i_dst_ip;
            src_ip_reg    <= i_src_ip;
            proto_reg     <= UDP_EN ? 8'd17 : i_protocol;
            src_port_reg  <= i_src_port;
            dst_port_reg  <= i_dst_port;
            pkt_id_reg    <= i_pkt_id;
            mf_reg        <= i_more_frame;
            frag_reg      <= i_frame_offset[15:3];
            len_reg       <= i_payload_len;
            total_len_reg <= total_len[15:0];
            rem_reg       <= i_payload_len;
         end
         if (state_reg == S_CALC) csum_reg <= ~csum_fold2;
         if (state_reg == S_PAYLOAD && i_in_vld && i_eth_rdy) rem_reg <= rem_reg - 16'd4;
      end
   end

endmodule

// File: tb/tb_ip_udp_frame_tx.sv
// Scoreboard bench for ip_udp_frame_tx: expected words are queued at request time and
// a negedge monitor compares every transferred output word against the queue.
module tb_ip_udp_frame_tx;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] m;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
   } item_t;

   logic        clk, rst, start, start0;
   logic [47:0] dst_mac, src_mac;
   logic [31:0] dst_ip, src_ip;
   logic [7:0]  protocol;
   logic [15:0] src_port, dst_port, pkt_id, frame_offset, payload_len, len0;
   logic        more_frame;
   logic [31:0] in_data;
   logic        in_vld, in_rdy, in_rdy0;
   logic [31:0] eth_data, eth_data0;
   logic        eth_sop, eth_eop, eth_vld, eth_sop0, eth_eop0, eth_vld0;
   logic [1:0]  eth_empty, eth_empty0;
   logic        eth_rdy, ready, err, ready0, err0;

   item_t       exp_q[$];
   logic [31:0] src_q[$];
   int          total = 0, bad = 0, cyc = 0;
   int          acc_cyc = 0, sop_cyc = 0, widx = 99, nsop = 0, vcount = 0, n0 = 0;
   logic        bp_mode = 1'b0, gap_en = 1'b0, took = 1'b0;
   logic        held_v = 1'b0, chk_rdy = 1'b0;
   logic [31:0] held_d = 32'h0, rs;
   logic [31:0] cap [11];
   item_t       it;

   ip_udp_frame_tx #(.TTL(8'hC8), .DSCP_ECN(8'h00), .UDP_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .i_start(start), .o_ready(ready), .o_err(err),
      .i_dst_mac(dst_mac), .i_src_mac(src_mac), .i_dst_ip(dst_ip), .i_src_ip(src_ip),
      .i_protocol(protocol), .i_src_port(src_port), .i_dst_port(dst_port),
      .i_pkt_id(pkt_id), .i_more_frame(more_frame), .i_frame_offset(frame_offset),
      .i_payload_len(payload_len), .i_in_data(in_data), .i_in_vld(in_vld), .o_in_rdy(in_rdy),
      .o_eth_data(eth_data), .o_eth_sop(eth_sop), .o_eth_eop(eth_eop),
      .o_eth_empty(eth_empty), .o_eth_vld(eth_vld), .i_eth_rdy(eth_rdy)
   );

   ip_udp_frame_tx #(.TTL(8'hC8), .DSCP_ECN(8'h00), .UDP_EN(1'b0)) dut_raw (
      .clk(clk), .rst(rst), .i_start(start0), .o_ready(ready0), .o_err(err0),
      .i_dst_mac(dst_mac), .i_src_mac(src_mac), .i_dst_ip(dst_ip), .i_src_ip(src_ip),
      .i_protocol(protocol), .i_src_port(src_port), .i_dst_port(dst_port),
      .i_pkt_id(pkt_id), .i_more_frame(more_frame), .i_frame_offset(frame_offset),
      .i_payload_len(len0), .i_in_data(in_data), .i_in_vld(in_vld), .o_in_rdy(in_rdy0),
      .o_eth_data(eth_data0), .o_eth_sop(eth_sop0), .o_eth_eop(eth_eop0),
      .o_eth_empty(eth_empty0), .o_eth_vld(eth_vld0), .i_eth_rdy(eth_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%b want=%b", name, got, want);
      end
   endtask

   task automatic push_w(input logic [31:0] d, input logic [31:0] m, input logic s,
                         input logic e, input logic [1:0] emp);
      item_t x;
      x.d = d; x.m = m; x.sop = s; x.eop = e; x.empty = emp;
      exp_q.push_back(x);
   endtask

   task automatic set_defaults();
      dst_mac = 48'h0011_2233_4455; src_mac = 48'h6677_8899_AABB;
      src_ip = 32'hC0A8_010A; dst_ip = 32'hC0A8_0101; protocol = 8'd6;
      src_port = 16'h1000; dst_port = 16'h2000;
   endtask

   // Queue the hand-computed header words plus payload, load the source, then issue the request.
   task automatic frame(input logic [31:0] ip0, input logic [31:0] ip1, input logic [31:0] ip2,
                        input logic [31:0] ip2_m, input logic [31:0] udp1, input logic [15:0] len,
                        input logic [15:0] id, input logic more, input logic [15:0] off,
                        input logic [7:0] base);
      int nw;
      logic [31:0] d, s;
      logic [7:0]  b;
      logic [1:0]  e;
      push_w(32'h0000_0011, '1, 1'b1, 1'b0, 2'd0);
      push_w(32'h2233_4455, '1, 1'b0, 1'b0, 2'd0);
      push_w(32'h6677_8899, '1, 1'b0, 1'b0, 2'd0);
      push_w(32'hAABB_0800, '1, 1'b0, 1'b0, 2'd0);
      push_w(ip0, '1, 1'b0, 1'b0, 2'd0);
      push_w(ip1, '1, 1'b0, 1'b0, 2'd0);
      push_w(ip2, ip2_m, 1'b0, 1'b0, 2'd0);
      push_w(32'hC0A8_010A, '1, 1'b0, 1'b0, 2'd0);
      push_w(32'hC0A8_0101, '1, 1'b0, 1'b0, 2'd0);
      push_w(32'h1000_2000, '1, 1'b0, 1'b0, 2'd0);
      push_w(udp1, '1, 1'b0, (len == 16'd0), 2'd0);
      nw = (int'(len) + 3) / 4;
      e = 2'((4 - (int'(len) % 4)) % 4);
      @(posedge clk); #1;
      for (int w = 0; w < nw; w++) begin
         d = 32'h0; s = 32'h0;
         for (int k = 0; k < 4; k++) begin
            b = base + 8'(4 * w + k);
            s[31 - 8 * k -: 8] = b;
            if (4 * w + k < int'(len)) d[31 - 8 * k -: 8] = b;
         end
         src_q.push_back(s);
         push_w(d, '1, 1'b0, (w == nw - 1), (w == nw - 1) ? e : 2'd0);
      end
      payload_len = len; pkt_id = id; more_frame = more; frame_offset = off;
      start = 1'b1;
      @(negedge clk);
      acc_cyc = cyc;
      check1("accept_ready", ready, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !ready) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_drained", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic reject_udp(input logic [15:0] len);
      @(posedge clk); #1;
      payload_len = len; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check1("rej_err", err, 1'b1);
      check1("rej_ready", ready, 1'b1);
      check1("rej_vld", eth_vld, 1'b0);
      @(negedge clk);
      check1("rej_err_pulse", err, 1'b0);
   endtask

   // sink: always ready, or toggling every cycle under backpressure
   initial begin
      eth_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         eth_rdy = bp_mode ? ~eth_rdy : 1'b1;
      end
   end

   // payload source: holds each word until taken, optional random gaps, drops everything on reset
   initial begin
      in_vld = 1'b0; in_data = 32'h0;
      forever begin
         @(negedge clk);
         took = in_vld && in_rdy;
         @(posedge clk); #1;
         if (rst) begin
            in_vld = 1'b0;
            src_q.delete();
         end else begin
            if (took) in_vld = 1'b0;
            if (!in_vld && src_q.size() != 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
               in_data = src_q.pop_front();
               in_vld = 1'b1;
            end
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
            chk_rdy = 1'b0;
         end else begin
            if (chk_rdy) begin
               check1("ready_after_eop", ready, 1'b1);
               chk_rdy = 1'b0;
            end
            if (held_v) begin
               check1("stall_vld", eth_vld, 1'b1);
               check("stall_data", eth_data, held_d);
            end
            held_v = eth_vld && !eth_rdy;
            held_d = eth_data;
            if (eth_vld && eth_rdy) begin
               if (eth_sop) begin
                  widx = 0;
                  sop_cyc = cyc;
                  nsop++;
               end
               if (widx < 11) begin
                  check1("hdr_in_rdy", in_rdy, 1'b0);
                  cap[widx] = eth_data;
               end
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_word: got=%h want=none", eth_data);
               end else begin
                  it = exp_q.pop_front();
                  check($sformatf("word%0d_data", widx), eth_data & it.m, it.d & it.m);
                  check1($sformatf("word%0d_sop", widx), eth_sop, it.sop);
                  check1($sformatf("word%0d_eop", widx), eth_eop, it.eop);
                  check($sformatf("word%0d_empty", widx), {30'd0, eth_empty}, {30'd0, it.empty});
               end
               if (eth_eop) begin
                  rs = 32'h0;
                  for (int k = 4; k < 9; k++)
                     rs = rs + {16'h0, cap[k][31:16]} + {16'h0, cap[k][15:0]};
                  rs = {16'h0, rs[15:0]} + {16'h0, rs[31:16]};
                  rs = {16'h0, rs[15:0]} + {16'h0, rs[31:16]};
                  check("ip_resum", {16'h0, rs[15:0]}, 32'h0000_FFFF);
                  chk_rdy = 1'b1;
               end
               widx++;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; start0 = 1'b0; len0 = 16'd0;
      pkt_id = 16'h0; more_frame = 1'b0; frame_offset = 16'h0; payload_len = 16'h0;
      set_defaults();
      repeat (2) @(negedge clk);
      check1("rst_ready", ready, 1'b1);
      check1("rst_err", err, 1'b0);
      check1("rst_in_rdy", in_rdy, 1'b0);
      check1("rst_vld", eth_vld, 1'b0);
      check1("rst_sop", eth_sop, 1'b0);
      check1("rst_eop", eth_eop, 1'b0);
      check("rst_empty", {30'd0, eth_empty}, 32'd0);
      check("rst_data", eth_data, 32'd0);
      @(posedge clk); #3;
      rst = 1'b0;

      // A: UDP, 10 bytes, latency
      frame(32'h4500_0026, 32'h1234_4000, 32'hC811_0000, 32'hFFFF_0000, 32'h0012_0000,
            16'd10, 16'h1234, 1'b0, 16'd0, 8'hA0);
      wait_done(200);
      check("sop_latency", sop_cyc - acc_cyc, 32'd2);

      // B: exact checksum for 192.168.1.10 -> 192.168.1.1, total 46
      frame(32'h4500_002E, 32'h0000_4000, 32'hC811_2F63, 32'hFFFF_FFFF, 32'h001A_0000,
            16'd18, 16'h0000, 1'b0, 16'd0, 8'h10);
      wait_done(200);

      // C: fragment under backpressure and source gaps; inputs scrambled mid-frame
      bp_mode = 1'b1; gap_en = 1'b1;
      frame(32'h4500_0023, 32'h0042_20B9, 32'hC811_0000, 32'hFFFF_0000, 32'h000F_0000,
            16'd7, 16'h0042, 1'b1, 16'd1485, 8'h30);
      dst_mac = '1; src_mac = 48'h0; src_ip = 32'h0; dst_ip = 32'hDEAD_BEEF;
      src_port = 16'h0; dst_port = 16'h0; pkt_id = 16'hFFFF; payload_len = 16'd3;
      more_frame = 1'b0; frame_offset = 16'h0; start = 1'b1;
      repeat (5) @(posedge clk);
      #1 start = 1'b0;
      set_defaults();
      wait_done(400);
      bp_mode = 1'b0; gap_en = 1'b0;

      // F: UDP with empty payload, non-zero offset clears DF
      frame(32'h4500_001C, 32'h0099_0002, 32'hC811_0000, 32'hFFFF_0000, 32'h0008_0000,
            16'd0, 16'h0099, 1'b0, 16'd16, 8'h00);
      wait_done(200);

      // rejects: oversize totals on the UDP instance, zero length on the raw instance
      reject_udp(16'hFFF0);
      reject_udp(16'hFFE4);
      @(posedge clk); #1;
      len0 = 16'd0; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      @(negedge clk);
      check1("rej0_err", err0, 1'b1);
      check1("rej0_ready", ready0, 1'b1);
      vcount = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (eth_vld0) vcount++;
         if (i == 0) check1("rej0_err_pulse", err0, 1'b0);
      end
      check("rej0_no_vld", vcount, 32'd0);
      check1("rej0_ready_after", ready0, 1'b1);
      check1("rej0_in_rdy", in_rdy0, 1'b0);
      check("rej0_outputs", {eth_data0[28:0], eth_sop0, eth_eop0, |eth_empty0}, 32'd0);

      // D: reset in the middle of payload, then E is sent cleanly
      n0 = nsop;
      frame(32'h4500_0044, 32'h0005_4000, 32'hC811_0000, 32'hFFFF_0000, 32'h0030_0000,
            16'd40, 16'h0005, 1'b0, 16'd0, 8'h70);
      vcount = 0;
      while (!(nsop == n0 + 1 && widx >= 13) && vcount < 200) begin
         @(negedge clk);
         vcount++;
      end
      check("mid_payload_reached", {31'd0, (nsop == n0 + 1 && widx >= 13)}, 32'd1);
      @(posedge clk); #3;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check1("mrst_ready", ready, 1'b1);
      check1("mrst_vld", eth_vld, 1'b0);
      check1("mrst_in_rdy", in_rdy, 1'b0);
      check1("mrst_eop", eth_eop, 1'b0);
      check("mrst_data", eth_data, 32'd0);
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b0;
      frame(32'h4500_0024, 32'h0006_4000, 32'hC811_0000, 32'hFFFF_0000, 32'h0010_0000,
            16'd8, 16'h0006, 1'b0, 16'd0, 8'h60);
      wait_done(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
